multicycle_main_control: RTL and testbench
==========================================

# multicycle_main_control

Moore-style main control FSM for the multicycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives every datapath enable and mux select, and produces the 2-bit `ALUOp` consumed by the downstream ALU-control decoder.
- Sits between the instruction register (which supplies `opcode`) and the ALU-control / datapath.

## Interface
Parameters: none. Opcode values are fixed: R-type `000000`, lw `100011`, sw `101011`, beq `000100`, j `000010`.

Ports:
- `clk` in 1: single clock, all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `opcode` in 6: instruction bits [31:26] from the instruction register; sampled only in DECODE.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `MemtoReg`, `IRWrite`, `ALUSrcA`, `RegWrite`, `RegDst` out 1: datapath controls.
- `PCSource` out 2: 00 ALU result, 01 ALUOut, 10 jump target.
- `ALUSrcB` out 2: 00 B reg, 01 constant 4, 10 sign-extended imm, 11 sign-extended imm << 2.
- `ALUOp` out 2: 00 add, 01 subtract, 10 R-type funct decode, 11 jump.
- `state` out 4: current state code, for debug and verification.
- `instr_done` out 1: high during the final cycle of every instruction.
- `illegal_op` out 1: sticky; set when DECODE sees an unsupported opcode.

## Operation
State encoding:
- 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMREAD, 4 MEMWB
- 5 MEMWRITE, 6 EXECUTE, 7 RTYPE_WB, 8 BRANCH, 9 JUMP
- Codes 10–15 are unreachable and transition to FETCH.

Transitions:
- FETCH → DECODE.
- DECODE → MEMADR for lw/sw; EXECUTE for R-type; BRANCH for beq; JUMP for j; FETCH for any other opcode.
- MEMADR → MEMREAD for lw, MEMWRITE for sw. The opcode is registered in DECODE; `opcode` is not re-sampled.
- MEMREAD → MEMWB.
- EXECUTE → RTYPE_WB.
- MEMWB, MEMWRITE, RTYPE_WB, BRANCH, JUMP → FETCH.

Outputs are a pure function of the state register. Any signal not listed for a state is 0.
- FETCH: MemRead=1, IRWrite=1, ALUSrcB=01, ALUOp=00, PCWrite=1, PCSource=00.
- DECODE: ALUSrcB=11, ALUOp=00.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
- MEMREAD: MemRead=1, IorD=1.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0.
- MEMWRITE: MemWrite=1, IorD=1.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
- RTYPE_WB: RegWrite=1, RegDst=1.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01.
- JUMP: PCWrite=1, PCSource=10, ALUOp=11.

`instr_done`:
- 1 in MEMWB, MEMWRITE, RTYPE_WB, BRANCH, JUMP.
- Also 1 in DECODE when the opcode is unsupported; this is a combinational decode of state and `opcode` in that one case.

`illegal_op`:
- Set on the clock edge leaving DECODE with an unsupported opcode.
- Cleared only by `reset`.

## Timing
- Reset: on a rising edge with `reset`=1, state ← FETCH (0), `illegal_op` ← 0, and the registered opcode ← 0.
- While `reset` is high, all control outputs and `instr_done` are forced to 0; `state` still reads its register value. This prevents writes during reset.
- Reset mid-instruction abandons the instruction. The next cycle after release is FETCH.
- Cycles per instruction, counting from the FETCH cycle inclusive: lw 5, sw 4, R-type 4, beq 3, j 3, illegal 2.
- `opcode` must be stable in the DECODE cycle. The instruction register loads at the end of FETCH via IRWrite.
- No stalls or handshakes: memory is single-cycle, and the FSM advances every clock.

## Test plan
- Reset then idle, `opcode`=000000: `state` sequence 0,1,6,7,0. RTYPE_WB shows RegWrite=1, RegDst=1; `instr_done` is high only in the state-7 cycle.
- lw (100011): `state` 0,1,2,3,4,0. MEMREAD shows MemRead=1, IorD=1; MEMWB shows MemtoReg=1, RegWrite=1. `opcode` changed to 101011 during MEMADR must not divert the path to MEMWRITE.
- sw then beq back-to-back:
  - sw: states 0,1,2,5, with MemWrite=1 in state 5.
  - beq: states 0,1,8, with ALUOp=01, PCWriteCond=1, PCSource=01 in state 8.
  - FETCH shows PCWrite=1, IRWrite=1, ALUSrcB=01 each time.
- j (000010): states 0,1,9,0. JUMP shows PCWrite=1, PCSource=10, ALUOp=11.
- Illegal opcode 111111: states 0,1,0. `instr_done`=1 in DECODE; `illegal_op` rises after DECODE and stays 1 through a following valid R-type, clearing only after `reset`.
- `reset` asserted during lw MEMREAD: next state 0. All outputs read 0 while reset is high. After release, a FETCH cycle occurs with MemRead=1, IRWrite=1, PCWrite=1.

Source files
------------

// File: rtl/multicycle_main_control.sv
// multicycle_main_control
// Moore-style main control FSM for the multicycle MIPS datapath.
// Steps each instruction through fetch/decode/execute/memory/writeback and
// drives every datapath enable, mux select and the 2-bit ALUOp.

module multicycle_main_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    RTYPE_WB = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9
  } state_t;

  state_t     stateReg;
  state_t     nextState;
  logic [5:0] opReg;
  logic       opSupported;

  // True when the live opcode is one the FSM knows how to sequence
  always_comb begin
    opSupported = 1'b0;
    case (opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: opSupported = 1'b1;
      default:                              opSupported = 1'b0;
    endcase
  end

  // State register; reset always lands in FETCH
  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg <= FETCH;
    end else begin
      stateReg <= nextState;
    end
  end

  // Opcode is captured when leaving DECODE so MEMADR ignores later IR changes
  always_ff @(posedge clk) begin
    if (reset) begin
      opReg <= 6'b000000;
    end else if (stateReg == DECODE) begin
      opReg <= opcode;
    end
  end

  // Sticky flag for an unsupported opcode seen in DECODE, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_op <= 1'b0;
    end else if ((stateReg == DECODE) && !opSupported) begin
      illegal_op <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    nextState = FETCH;
    case (stateReg)
      FETCH: nextState = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: nextState = MEMADR;
          OP_RTYPE:     nextState = EXECUTE;
          OP_BEQ:       nextState = BRANCH;
          OP_J:         nextState = JUMP;
          default:      nextState = FETCH;
        endcase
      end
      MEMADR: begin
        if (opReg == OP_LW) begin
          nextState = MEMREAD;
        end else if (opReg == OP_SW) begin
          nextState = MEMWRITE;
        end else begin
          nextState = FETCH;
        end
      end
      MEMREAD:  nextState = MEMWB;
      EXECUTE:  nextState = RTYPE_WB;
      MEMWB, MEMWRITE, RTYPE_WB, BRANCH, JUMP: nextState = FETCH;
      default:  nextState = FETCH;
    endcase
  end

  // Moore outputs from the state register, all forced low while reset is held
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    instr_done  = 1'b0;
    case (stateReg)
      FETCH: begin
        MemRead  = 1'b1;
        IRWrite  = 1'b1;
        ALUSrcB  = 2'b01;
        ALUOp    = 2'b00;
        PCWrite  = 1'b1;
        PCSource = 2'b00;
      end
      DECODE: begin
        ALUSrcB    = 2'b11;
        ALUOp      = 2'b00;
        instr_done = !opSupported;
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b00;
      end
      MEMREAD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        RegDst     = 1'b0;
        instr_done = 1'b1;
      end
      MEMWRITE: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = 1'b1;
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b00;
        ALUOp   = 2'b10;
      end
      RTYPE_WB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        instr_done  = 1'b1;
      end
      JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        ALUOp      = 2'b11;
        instr_done = 1'b1;
      end
      default: begin
        instr_done = 1'b0;
      end
    endcase
    if (reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      MemtoReg    = 1'b0;
      IRWrite     = 1'b0;
      ALUSrcA     = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      PCSource    = 2'b00;
      ALUSrcB     = 2'b00;
      ALUOp       = 2'b00;
      instr_done  = 1'b0;
    end
  end

  assign state = stateReg;

endmodule

// File: tb/tb_multicycle_main_control.sv
// tb_multicycle_main_control
// Directed bench for the multicycle main control FSM; expected control words
// per state are written out field by field from the state output table.

module tb_multicycle_main_control;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, ALUSrcA, RegWrite, RegDst;
  logic [1:0] PCSource, ALUSrcB, ALUOp;
  logic [3:0] state;
  logic       instr_done;
  logic       illegal_op;
  logic [15:0] ctrlWord;

  int checkCount = 0;
  int failCount  = 0;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BAD   = 6'b111111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // Field order: PCWrite PCWriteCond IorD MemRead MemWrite MemtoReg IRWrite
  //              ALUSrcA RegWrite RegDst PCSource ALUSrcB ALUOp
  localparam logic [15:0] C_ZERO     = 16'h0000;
  localparam logic [15:0] C_FETCH    = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b01,2'b00};
  localparam logic [15:0] C_DECODE   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b11,2'b00};
  localparam logic [15:0] C_MEMADR   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b10,2'b00};
  localparam logic [15:0] C_MEMREAD  = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00};
  localparam logic [15:0] C_MEMWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00};
  localparam logic [15:0] C_MEMWRITE = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00};
  localparam logic [15:0] C_EXECUTE  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b10};
  localparam logic [15:0] C_RTYPEWB  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,2'b00,2'b00,2'b00};
  localparam logic [15:0] C_BRANCH   = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b01,2'b00,2'b01};
  localparam logic [15:0] C_JUMP     = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b11};

  multicycle_main_control dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MemtoReg    (MemtoReg),
    .IRWrite     (IRWrite),
    .ALUSrcA     (ALUSrcA),
    .RegWrite    (RegWrite),
    .RegDst      (RegDst),
    .PCSource    (PCSource),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .state       (state),
    .instr_done  (instr_done),
    .illegal_op  (illegal_op)
  );

  assign ctrlWord = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                     ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp};

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic rst, input logic [5:0] op);
    reset  = rst;
    opcode = op;
    #1;
  endtask

  // Advance one clock and sample well after the edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkCycle(input string tag, input logic [3:0] expState, input logic [15:0] expCtrl,
                            input logic expDone, input logic expIllegal);
    checkOutput({tag, "/state"},   {12'h000, state},      {12'h000, expState});
    checkOutput({tag, "/ctrl"},    ctrlWord,              expCtrl);
    checkOutput({tag, "/done"},    {15'h0000, instr_done}, {15'h0000, expDone});
    checkOutput({tag, "/illegal"}, {15'h0000, illegal_op}, {15'h0000, expIllegal});
  endtask

  initial begin
    reset  = 1'b1;
    opcode = OP_RTYPE;
    tick();
    tick();
    checkCycle("reset_hold", 4'd0, C_ZERO, 1'b0, 1'b0);

    // R-type: 0,1,6,7,0
    applyStimulus(1'b0, OP_RTYPE);
    checkCycle("rt_fetch", 4'd0, C_FETCH, 1'b0, 1'b0);
    tick(); checkCycle("rt_decode", 4'd1, C_DECODE, 1'b0, 1'b0);
    tick(); checkCycle("rt_exec",   4'd6, C_EXECUTE, 1'b0, 1'b0);
    tick(); checkCycle("rt_wb",     4'd7, C_RTYPEWB, 1'b1, 1'b0);
    tick(); checkCycle("rt_next",   4'd0, C_FETCH, 1'b0, 1'b0);

    // lw with opcode switched to sw during MEMADR: 0,1,2,3,4,0
    applyStimulus(1'b0, OP_LW);
    tick(); checkCycle("lw_decode", 4'd1, C_DECODE, 1'b0, 1'b0);
    tick(); checkCycle("lw_memadr", 4'd2, C_MEMADR, 1'b0, 1'b0);
    applyStimulus(1'b0, OP_SW);
    tick(); checkCycle("lw_memrd",  4'd3, C_MEMREAD, 1'b0, 1'b0);
    tick(); checkCycle("lw_memwb",  4'd4, C_MEMWB, 1'b1, 1'b0);
    tick(); checkCycle("lw_next",   4'd0, C_FETCH, 1'b0, 1'b0);

    // sw: 0,1,2,5
    tick(); checkCycle("sw_decode", 4'd1, C_DECODE, 1'b0, 1'b0);
    tick(); checkCycle("sw_memadr", 4'd2, C_MEMADR, 1'b0, 1'b0);
    tick(); checkCycle("sw_memwr",  4'd5, C_MEMWRITE, 1'b1, 1'b0);
    tick(); checkCycle("beq_fetch", 4'd0, C_FETCH, 1'b0, 1'b0);

    // beq back-to-back: 0,1,8
    applyStimulus(1'b0, OP_BEQ);
    tick(); checkCycle("beq_decode", 4'd1, C_DECODE, 1'b0, 1'b0);
    tick(); checkCycle("beq_branch", 4'd8, C_BRANCH, 1'b1, 1'b0);
    tick(); checkCycle("j_fetch",    4'd0, C_FETCH, 1'b0, 1'b0);

    // j: 0,1,9,0
    applyStimulus(1'b0, OP_J);
    tick(); checkCycle("j_decode", 4'd1, C_DECODE, 1'b0, 1'b0);
    tick(); checkCycle("j_jump",   4'd9, C_JUMP, 1'b1, 1'b0);
    tick(); checkCycle("bad_fetch", 4'd0, C_FETCH, 1'b0, 1'b0);

    // Illegal 111111: 0,1,0 with done in DECODE, then sticky flag
    applyStimulus(1'b0, OP_BAD);
    tick(); checkCycle("bad_decode", 4'd1, C_DECODE, 1'b1, 1'b0);
    tick(); checkCycle("bad_next",   4'd0, C_FETCH, 1'b0, 1'b1);
    applyStimulus(1'b0, OP_RTYPE);
    tick(); checkCycle("sticky_decode", 4'd1, C_DECODE, 1'b0, 1'b1);
    tick(); checkCycle("sticky_exec",   4'd6, C_EXECUTE, 1'b0, 1'b1);
    tick(); checkCycle("sticky_wb",     4'd7, C_RTYPEWB, 1'b1, 1'b1);
    tick(); checkCycle("sticky_fetch",  4'd0, C_FETCH, 1'b0, 1'b1);

    // Another unsupported opcode (addi)
    applyStimulus(1'b0, OP_ADDI);
    tick(); checkCycle("addi_decode", 4'd1, C_DECODE, 1'b1, 1'b1);
    tick(); checkCycle("addi_next",   4'd0, C_FETCH, 1'b0, 1'b1);

    // Reset during lw MEMREAD
    applyStimulus(1'b0, OP_LW);
    tick(); checkCycle("rlw_decode", 4'd1, C_DECODE, 1'b0, 1'b1);
    tick(); checkCycle("rlw_memadr", 4'd2, C_MEMADR, 1'b0, 1'b1);
    tick(); checkCycle("rlw_memrd",  4'd3, C_MEMREAD, 1'b0, 1'b1);
    applyStimulus(1'b1, OP_LW);
    checkCycle("rlw_rst_in_memrd", 4'd3, C_ZERO, 1'b0, 1'b1);
    tick(); checkCycle("rlw_rst_edge", 4'd0, C_ZERO, 1'b0, 1'b0);
    applyStimulus(1'b0, OP_LW);
    checkCycle("rlw_release", 4'd0, C_FETCH, 1'b0, 1'b0);
    tick(); checkCycle("rlw_decode2", 4'd1, C_DECODE, 1'b0, 1'b0);
    tick(); checkCycle("rlw_memadr2", 4'd2, C_MEMADR, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
